// File: rtl/pwm_gen_pkg.sv
// Shared PWM definitions: mode encodings and mode field width.
package pwm_gen_pkg;

    localparam int         PWM_MODE_W    = 2;
    localparam logic [1:0] PWM_MODE_LOW  = 2'd0;
    localparam logic [1:0] PWM_MODE_HIGH = 2'd1;
    localparam logic [1:0] PWM_MODE_PWM  = 2'd2;
    localparam logic [1:0] PWM_MODE_RSVD = 2'd3;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one-clock tick every presc+1 clocks, restartable by a sync clear.
module pwm_prescaler #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PRESC_W-1:0] presc,
    input  logic               clr,
    output logic               tick
);

    logic [PRESC_W-1:0] pcnt_q;
    logic [PRESC_W-1:0] pcnt_d;

    // >= rather than == so that shrinking presc mid-count ticks at once
    // instead of wrapping through the whole counter range.
    always_comb begin
        tick   = (pcnt_q >= presc);
        pcnt_d = pcnt_q + PRESC_W'(1);
        if (clr || tick) begin
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/pwm_gen.sv
// Double-buffered PWM/servo pulse generator for one pin.
// Optional period watchdog enabled by defining PWM_WATCHDOG_EN.
module pwm_gen
    import pwm_gen_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int PRESC_W    = 8,
    parameter int WD_PERIODS = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PRESC_W-1:0]    presc,
    input  logic                  wr_en,
    input  logic [PWM_MODE_W-1:0] wr_mode,
    input  logic [CNT_W-1:0]      wr_period,
    input  logic [CNT_W-1:0]      wr_duty,
    output logic                  wr_ready,
    output logic                  pwm_out,
    output logic                  period_st,
    output logic                  wd_trip
);

    // Write handshake: a write is taken on any clock where wr_en & wr_ready;
    // wr_ready stays low from the clock after acceptance until it is applied.

    logic [PWM_MODE_W-1:0] mode_sh_q,   mode_sh_d;
    logic [CNT_W-1:0]      period_sh_q, period_sh_d;
    logic [CNT_W-1:0]      duty_sh_q,   duty_sh_d;
    logic                  pend_q,      pend_d;
    logic [PWM_MODE_W-1:0] pmode_q,     pmode_d;
    logic [CNT_W-1:0]      pperiod_q,   pperiod_d;
    logic [CNT_W-1:0]      pduty_q,     pduty_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  pwm_out_q,   pwm_out_d;
    logic                  period_st_q, period_st_d;

    logic tick;
    logic accept;
    logic pwm_active;
    logic period_end;
    logic apply;
    logic wd_fire;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .presc (presc),
        .clr   (apply | wd_fire),
        .tick  (tick)
    );

    always_comb begin
        accept     = wr_en && !pend_q;
        pwm_active = (mode_sh_q == PWM_MODE_PWM) && (period_sh_q != '0);
        period_end = pwm_active && tick && (cnt_q == period_sh_q - CNT_W'(1));
        apply      = pend_q && ((mode_sh_q != PWM_MODE_PWM) ||
                                (period_sh_q == '0) || period_end);
    end

`ifdef PWM_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_PERIODS + 1);

    logic [WD_W-1:0] wd_cnt_q,  wd_cnt_d;
    logic            wd_trip_q, wd_trip_d;

    // A write landing on the same clock as the final period end re-arms the
    // watchdog rather than tripping it.
    always_comb begin
        wd_fire   = period_end && !accept && (wd_cnt_q == WD_W'(WD_PERIODS - 1));
        wd_cnt_d  = wd_cnt_q;
        wd_trip_d = wd_trip_q;
        if (accept || (mode_sh_q != PWM_MODE_PWM) || wd_fire) begin
            wd_cnt_d = '0;
        end else if (period_end) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
        if (accept) begin
            wd_trip_d = 1'b0;
        end else if (wd_fire) begin
            wd_trip_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_q  <= '0;
            wd_trip_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            wd_trip_q <= wd_trip_d;
        end
    end

    assign wd_trip = wd_trip_q;
`else
    logic unused_wd;
    assign unused_wd = ^WD_PERIODS;
    assign wd_fire   = 1'b0;
    assign wd_trip   = 1'b0;
`endif

    always_comb begin
        mode_sh_d   = mode_sh_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        pend_d      = pend_q;
        pmode_d     = pmode_q;
        pperiod_d   = pperiod_q;
        pduty_d     = pduty_q;
        cnt_d       = cnt_q;
        period_st_d = period_end;

        if (accept) begin
            pend_d    = 1'b1;
            pmode_d   = wr_mode;
            pperiod_d = wr_period;
            pduty_d   = wr_duty;
        end

        if (apply) begin
            mode_sh_d   = pmode_q;
            period_sh_d = pperiod_q;
            duty_sh_d   = pduty_q;
            pend_d      = 1'b0;
            cnt_d       = '0;
            period_st_d = (pmode_q == PWM_MODE_PWM) && (pperiod_q != '0);
        end else if (!pwm_active) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = period_end ? '0 : cnt_q + CNT_W'(1);
        end

        if (wd_fire) begin
            mode_sh_d   = PWM_MODE_LOW;
            pend_d      = 1'b0;
            cnt_d       = '0;
            period_st_d = 1'b0;
        end

        // Reserved mode falls through to low with LOW.
        pwm_out_d = (mode_sh_q == PWM_MODE_HIGH) || (pwm_active && (cnt_q < duty_sh_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_sh_q   <= PWM_MODE_LOW;
            period_sh_q <= '0;
            duty_sh_q   <= '0;
            pend_q      <= 1'b0;
            pmode_q     <= PWM_MODE_LOW;
            pperiod_q   <= '0;
            pduty_q     <= '0;
            cnt_q       <= '0;
            pwm_out_q   <= 1'b0;
            period_st_q <= 1'b0;
        end else begin
            mode_sh_q   <= mode_sh_d;
            period_sh_q <= period_sh_d;
            duty_sh_q   <= duty_sh_d;
            pend_q      <= pend_d;
            pmode_q     <= pmode_d;
            pperiod_q   <= pperiod_d;
            pduty_q     <= pduty_d;
            cnt_q       <= cnt_d;
            pwm_out_q   <= pwm_out_d;
            period_st_q <= period_st_d;
        end
    end

    assign wr_ready  = !pend_q;
    assign pwm_out   = pwm_out_q;
    assign period_st = period_st_q;

endmodule
